// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam logic [3:0]  COND_NEVER = 4'hF;
  localparam logic [31:0] NOP_CMD    = {COND_NEVER, 28'h000_0000};

  // Outstanding requests are capped at 7; a flush can drop all of them plus one.
  localparam int OUT_W  = 3;
  localparam int DROP_W = 4;

  typedef struct packed {
    logic [31:0] cmd;
    logic [31:0] ip;
  } fetch_entry_t;

  function automatic logic [31:0] align_hw(input logic [31:0] a);
    return {a[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Command FIFO of fetch entries with a registered head and a single-cycle flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_IP = 32'h0000_0000
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic                       head_valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  head_q, head_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_en, pop_en, write_en;

  always_comb begin
    pop_en   = pop && (count_q != '0);
    push_en  = push && ((count_q != CW'(DEPTH)) || pop_en);
    write_en = push_en && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_en) - CW'(pop_en);
    end

    // An empty FIFO shows a NOP but keeps the last IP on the head register.
    head_d = head_q;
    if (count_d == '0) begin
      head_d = '{cmd: NOP_CMD, ip: head_q.ip};
    end else if (write_en && (rd_ptr_d == wr_ptr_q)) begin
      head_d = push_data;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '{cmd: NOP_CMD, ip: align_hw(RESET_IP)};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clock) begin
    if (write_en) mem_q[wr_ptr_q] <= push_data;
  end

  assign head       = head_q;
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: issues halfword requests under a credit limit, pairs returns into
// 32-bit commands, queues them for stage 2 and redirects on stage-5 jumps.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] RESET_IP        = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enabled,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        ST2_valid,
  output logic [31:0] ST2_command,
  output logic [31:0] ST2_ip,
  output logic [31:0] ip_for_return
);

  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [31:0] START_IP = {RESET_IP[31:1], 1'b0};

  logic              run_q, run_d;
  logic [31:0]       addr_q, addr_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              half_pending_q, half_pending_d;
  logic [15:0]       low_half_q, low_half_d;
  logic [31:0]       resp_addr_q, resp_addr_d;

  logic [7:0]        reserved;
  logic              req, accept, keep, push, pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  logic              head_valid;
  logic [CW-1:0]     fifo_count;
  logic              unused_target_lsb;

  assign unused_target_lsb = jump_target[0];

  always_comb begin
    run_d = 1'b1;

    // Every FIFO slot costs two halfwords; in-flight and half-built words hold their share.
    reserved = 8'(fifo_count) * 8'd2 + 8'(half_pending_q) + 8'(out_q);
    req      = run_q && (out_q < OUT_W'(MAX_OUTSTANDING)) && (reserved < 8'(2 * DEPTH));
    accept   = req && imem_ready;
    keep     = imem_rvalid && (drop_q == '0);
    push     = keep && half_pending_q && !jump;
    pop      = head_valid && enabled && !jump;

    push_entry = '{cmd: {imem_rdata, low_half_q}, ip: resp_addr_q - 32'd1};

    out_d = out_q + OUT_W'(accept) - OUT_W'(imem_rvalid);

    drop_d = drop_q;
    if (jump) begin
      drop_d = DROP_W'(out_d);
    end else if (imem_rvalid && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end

    addr_d = addr_q;
    if (jump) begin
      addr_d = align_hw(jump_target);
    end else if (accept) begin
      addr_d = addr_q + 32'd1;
    end

    half_pending_d = half_pending_q;
    low_half_d     = low_half_q;
    resp_addr_d    = resp_addr_q;
    if (jump) begin
      half_pending_d = 1'b0;
      resp_addr_d    = align_hw(jump_target);
    end else if (keep) begin
      resp_addr_d = resp_addr_q + 32'd1;
      if (!half_pending_q) begin
        low_half_d     = imem_rdata;
        half_pending_d = 1'b1;
      end else begin
        half_pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      run_q          <= 1'b0;
      addr_q         <= START_IP;
      out_q          <= '0;
      drop_q         <= '0;
      half_pending_q <= 1'b0;
      low_half_q     <= '0;
      resp_addr_q    <= START_IP;
    end else begin
      run_q          <= run_d;
      addr_q         <= addr_d;
      out_q          <= out_d;
      drop_q         <= drop_d;
      half_pending_q <= half_pending_d;
      low_half_q     <= low_half_d;
      resp_addr_q    <= resp_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH    (DEPTH),
    .RESET_IP (RESET_IP)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (jump),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  assign imem_req      = req;
  assign imem_addr     = addr_q;
  assign ST2_valid     = head_valid;
  assign ST2_command   = head.cmd;
  assign ST2_ip        = head.ip;
  assign ip_for_return = head.ip + 32'd2;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a memory model returns address-as-data and a
// monitor checks every popped ST2 entry against the expected queue.
module tb_instr_fetch;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enabled = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        ST2_valid;
  logic [31:0] ST2_command;
  logic [31:0] ST2_ip;
  logic [31:0] ip_for_return;

  instr_fetch #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (4),
    .RESET_IP        (32'h0000_0000)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enabled       (enabled),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .jump          (jump),
    .jump_target   (jump_target),
    .ST2_valid     (ST2_valid),
    .ST2_command   (ST2_command),
    .ST2_ip        (ST2_ip),
    .ip_for_return (ip_for_return)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] ip;
    logic [31:0] ifr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  exp_t        exp_q[$];
  mreq_t       mem_q[$];
  logic [31:0] acc_log[$];
  int          cyc = 0;
  int          lat = 1;
  int          stall_left = 0;
  int          acc_count = 0;
  int          pops = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_min(input string name, input int act, input int need);
    n_vec++;
    if (act < need) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, need);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] ip);
    exp_t e;
    logic [15:0] lo;
    lo    = ip[15:0];
    e.cmd = {lo + 16'd1, lo};
    e.ip  = ip;
    e.ifr = ip + 32'd2;
    return e;
  endfunction

  task automatic load_stream(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(start + 32'(2 * i)));
  endtask

  // Memory: in-order, one return per cycle, 'lat' cycles after acceptance.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      imem_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (!reset_n) begin
        mem_q.delete();
        imem_rvalid = 1'b0;
      end else begin
        if (imem_req && imem_ready) begin
          mem_q.push_back('{addr: imem_addr, due: cyc + lat});
          acc_log.push_back(imem_addr);
          acc_count++;
        end
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_q[0].addr[15:0];
          void'(mem_q.pop_front());
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = 16'hDEAD;
        end
      end
    end
  end

  // Monitor: every entry consumed by stage 2 is compared with the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && ST2_valid && enabled && !jump) begin
        pops++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL st2_unexpected: got cmd %h ip %h, expected no entry", ST2_command, ST2_ip);
        end else begin
          e = exp_q.pop_front();
          check32("st2_cmd", ST2_command, e.cmd);
          check32("st2_ip", ST2_ip, e.ip);
          check32("ip_for_return", ip_for_return, e.ifr);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clock);
    #1;
    check32({tag, "_req"}, 32'(imem_req), 32'd0);
    check32({tag, "_addr"}, imem_addr, 32'h0000_0000);
    check32({tag, "_valid"}, 32'(ST2_valid), 32'd0);
    check32({tag, "_cmd"}, ST2_command, 32'hF000_0000);
    check32({tag, "_ip"}, ST2_ip, 32'h0000_0000);
    check32({tag, "_ifr"}, ip_for_return, 32'h0000_0002);
    reset_n = 1'b1;
  endtask

  initial begin
    int base, p0;
    bit found;
    logic [31:0] a0;

    // Reset and first two commands at zero wait.
    lat = 1;
    enabled = 1'b0;
    do_reset("rst0");
    exp_q.push_back('{cmd: 32'h0001_0000, ip: 32'h0000_0000, ifr: 32'h0000_0002});
    exp_q.push_back('{cmd: 32'h0003_0002, ip: 32'h0000_0002, ifr: 32'h0000_0004});
    load_stream(32'h4, 60);
    enabled = 1'b1;
    cycles(30);
    check_min("t1_pops", pops, 2);

    // Stalled stage 2: only DEPTH words worth of halfwords may be requested.
    enabled = 1'b0;
    do_reset("rst1");
    load_stream(32'h0, 64);
    base = acc_count;
    cycles(20);
    check32("t2_req_count", 32'(acc_count - base), 32'd8);
    check32("t2_req_idle", 32'(imem_req), 32'd0);
    check32("t2_valid", 32'(ST2_valid), 32'd1);
    check32("t2_cmd_stable", ST2_command, 32'h0001_0000);
    check32("t2_ip_stable", ST2_ip, 32'h0000_0000);
    p0 = pops;
    enabled = 1'b1;
    cycles(20);
    check_min("t2_pops", pops - p0, 4);

    // Memory back-pressure: request must hold.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req) found = 1'b1;
      else cycles(1);
    end
    check_min("t3_req_seen", int'(found), 1);
    stall_left = 3;
    a0 = imem_addr;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      check32("t3_addr_hold", imem_addr, a0);
      check32("t3_req_hold", 32'(imem_req), 32'd1);
    end
    p0 = pops;
    cycles(20);
    check_min("t3_pops", pops - p0, 4);

    // Latency 5, four in flight, jump to an odd target.
    lat = 5;
    enabled = 1'b1;
    do_reset("rst2");
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycles(1);
      if (mem_q.size() == 4) found = 1'b1;
    end
    check_min("t4_four_inflight", int'(found), 1);
    base = acc_count;
    jump = 1'b1;
    jump_target = 32'h0000_0101;
    exp_q.delete();
    exp_q.push_back('{cmd: 32'h0101_0100, ip: 32'h0000_0100, ifr: 32'h0000_0102});
    load_stream(32'h102, 40);
    cycles(1);
    jump = 1'b0;
    check32("t4_valid_after_jump", 32'(ST2_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycles(1);
      if (acc_count > base) found = 1'b1;
    end
    check_min("t4_new_request", int'(found), 1);
    if (found) check32("t4_first_addr", acc_log[base], 32'h0000_0100);
    p0 = pops;
    cycles(40);
    check_min("t4_pops", pops - p0, 3);

    // Jump, pop and a word-completing return on the same edge.
    lat = 1;
    enabled = 1'b0;
    do_reset("rst3");
    load_stream(32'h0, 64);
    cycles(20);
    enabled = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycles(1);
      if (ST2_valid && mem_q.size() > 0 && mem_q[0].due == cyc + 1 && mem_q[0].addr[0]) found = 1'b1;
    end
    check_min("t5_window", int'(found), 1);
    jump = 1'b1;
    jump_target = 32'h0000_0200;
    exp_q.delete();
    exp_q.push_back('{cmd: 32'h0201_0200, ip: 32'h0000_0200, ifr: 32'h0000_0202});
    load_stream(32'h202, 40);
    cycles(1);
    jump = 1'b0;
    check32("t5_valid_after_jump", 32'(ST2_valid), 32'd0);
    p0 = pops;
    cycles(30);
    check_min("t5_pops", pops - p0, 3);

    // Reset with a full FIFO.
    enabled = 1'b0;
    cycles(20);
    check32("t6_full_valid", 32'(ST2_valid), 32'd1);
    do_reset("rst4");
    load_stream(32'h0, 40);
    enabled = 1'b1;
    p0 = pops;
    cycles(30);
    check_min("t6_pops", pops - p0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
